// File: rtl/video_scan_gen.sv
// video_scan_gen: parametrised raster scan generator with pixel clock-enable, cell coordinates and frame strobes
module video_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP = 33,
  parameter int unsigned HSZ = 10,
  parameter int unsigned VSZ = 10,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int unsigned CELL_W = 8,
  parameter int unsigned CELL_H = 8,
  parameter int unsigned CXW = 3,
  parameter int unsigned CYW = 4,
  parameter int unsigned CW = 7,
  parameter int unsigned RW = 6,
  parameter int unsigned PIX_DIV = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  output logic           o_pix_stb,
  output logic [HSZ-1:0] o_hcount,
  output logic [VSZ-1:0] o_vcount,
  output logic           o_de,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic [CXW-1:0] o_cell_x,
  output logic [CYW-1:0] o_cell_y,
  output logic [CW-1:0]  o_text_col,
  output logic [RW-1:0]  o_text_row,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic           o_vblank_irq,
  output logic [15:0]    o_frame_count
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HSZ-1:0] H_LAST = HSZ'(H_TOTAL - 1);
  localparam logic [VSZ-1:0] V_LAST = VSZ'(V_TOTAL - 1);
  localparam logic [HSZ:0] H_ACT = (HSZ+1)'(H_ACTIVE);
  localparam logic [HSZ:0] H_SS = (HSZ+1)'(H_ACTIVE + H_FP);
  localparam logic [HSZ:0] H_SE = (HSZ+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VSZ:0] V_ACT = (VSZ+1)'(V_ACTIVE);
  localparam logic [VSZ:0] V_SS = (VSZ+1)'(V_ACTIVE + V_FP);
  localparam logic [VSZ:0] V_SE = (VSZ+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CXW-1:0] CX_LAST = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(CELL_H - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HSZ-1:0] hcount_q, hcount_d, h_nxt;
  logic [VSZ-1:0] vcount_q, vcount_d, v_nxt;
  logic [CXW-1:0] cell_x_q, cell_x_d;
  logic [CYW-1:0] cell_y_q, cell_y_d;
  logic [CW-1:0] text_col_q, text_col_d;
  logic [RW-1:0] text_row_q, text_row_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d, vblank_q, vblank_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic pix_stb, h_wrap, v_wrap, line_wrap, h_vis, v_vis, cx_last, cy_last;

  // next-state for divider, scan counters, cell counters and event strobes
  always_comb begin
    pix_stb = i_en && div_q == DIV_LAST;
    h_wrap = hcount_q == H_LAST;
    v_wrap = vcount_q == V_LAST;
    line_wrap = pix_stb && h_wrap;
    h_nxt = h_wrap ? '0 : hcount_q + HSZ'(1);
    v_nxt = v_wrap ? '0 : vcount_q + VSZ'(1);
    h_vis = h_nxt != '0 && {1'b0, h_nxt} < H_ACT;
    v_vis = v_nxt != '0 && {1'b0, v_nxt} < V_ACT;
    cx_last = cell_x_q == CX_LAST;
    cy_last = cell_y_q == CY_LAST;
    div_d = !i_en ? div_q : pix_stb ? '0 : div_q + DW'(1);
    hcount_d = pix_stb ? h_nxt : hcount_q;
    vcount_d = line_wrap ? v_nxt : vcount_q;
    cell_x_d = !pix_stb ? cell_x_q : (!h_vis || cx_last) ? '0 : cell_x_q + CXW'(1);
    text_col_d = !pix_stb ? text_col_q : !h_vis ? '0 : cx_last ? text_col_q + CW'(1) : text_col_q;
    cell_y_d = !line_wrap ? cell_y_q : (!v_vis || cy_last) ? '0 : cell_y_q + CYW'(1);
    text_row_d = !line_wrap ? text_row_q : !v_vis ? '0 : cy_last ? text_row_q + RW'(1) : text_row_q;
    line_start_d = line_wrap;
    frame_start_d = line_wrap && v_wrap;
    vblank_d = line_wrap && {1'b0, v_nxt} == V_ACT;
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  // state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      cell_x_q <= '0;
      cell_y_q <= '0;
      text_col_q <= '0;
      text_row_q <= '0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_q <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      text_col_q <= text_col_d;
      text_row_q <= text_row_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q <= vblank_d;
      frame_count_q <= frame_count_d;
    end
  end

  // output decodes from the registered counters
  always_comb begin
    o_pix_stb = pix_stb;
    o_hcount = hcount_q;
    o_vcount = vcount_q;
    o_de = {1'b0, hcount_q} < H_ACT && {1'b0, vcount_q} < V_ACT;
    o_hsync = ({1'b0, hcount_q} >= H_SS && {1'b0, hcount_q} < H_SE) ? H_SYNC_POL : !H_SYNC_POL;
    o_vsync = ({1'b0, vcount_q} >= V_SS && {1'b0, vcount_q} < V_SE) ? V_SYNC_POL : !V_SYNC_POL;
    o_cell_x = cell_x_q;
    o_cell_y = cell_y_q;
    o_text_col = text_col_q;
    o_text_row = text_row_q;
    o_line_start = line_start_q;
    o_frame_start = frame_start_q;
    o_vblank_irq = vblank_q;
    o_frame_count = frame_count_q;
  end
endmodule

// File: tb/tb_video_scan_gen.sv
// tb_video_scan_gen: reference-model and vector checks of the raster scan generator
module tb_video_scan_gen;
  localparam int HA = 20, HFP = 2, HS = 3, HBP = 3, VA = 12, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP, VT = VA + VFP + VS + VBP, FR = HT * VT;
  localparam int CWID = 3, CHGT = 5, PD = 3, CWB = 2, RWB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic a_stb, a_de, a_hs, a_vs, a_ls, a_fs, a_vb;
  logic [4:0] a_h, a_v;
  logic [1:0] a_cx;
  logic [2:0] a_cy;
  logic [CWB-1:0] a_col;
  logic [RWB-1:0] a_row;
  logic [15:0] a_fc;

  video_scan_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .HSZ(5), .VSZ(5),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CELL_W(CWID), .CELL_H(CHGT),
    .CXW(2), .CYW(3), .CW(CWB), .RW(RWB), .PIX_DIV(PD)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .o_pix_stb(a_stb), .o_hcount(a_h),
    .o_vcount(a_v), .o_de(a_de), .o_hsync(a_hs), .o_vsync(a_vs), .o_cell_x(a_cx),
    .o_cell_y(a_cy), .o_text_col(a_col), .o_text_row(a_row), .o_line_start(a_ls),
    .o_frame_start(a_fs), .o_vblank_irq(a_vb), .o_frame_count(a_fc));

  logic rst_b = 1'b1, en_b = 1'b0;
  logic b_stb, b_de, b_hs, b_vs, b_ls, b_fs, b_vb;
  logic [3:0] b_h;
  logic [2:0] b_v;
  logic [2:0] b_cx;
  logic [3:0] b_cy;
  logic [6:0] b_col;
  logic [5:0] b_row;
  logic [15:0] b_fc;

  video_scan_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HSZ(4), .VSZ(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .o_pix_stb(b_stb), .o_hcount(b_h),
    .o_vcount(b_v), .o_de(b_de), .o_hsync(b_hs), .o_vsync(b_vs), .o_cell_x(b_cx),
    .o_cell_y(b_cy), .o_text_col(b_col), .o_text_row(b_row), .o_line_start(b_ls),
    .o_frame_start(b_fs), .o_vblank_irq(b_vb), .o_frame_count(b_fc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  int ph = 0, p = 0;
  bit stepped = 0;

  task automatic check_a();
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    chk("a_pix_stb", a_stb, en_a && ph == PD - 1);
    chk("a_hcount", a_h, h);
    chk("a_vcount", a_v, v);
    chk("a_de", a_de, h < HA && v < VA);
    chk("a_hsync", a_hs, !(h >= HA + HFP && h < HA + HFP + HS));
    chk("a_vsync", a_vs, !(v >= VA + VFP && v < VA + VFP + VS));
    chk("a_cell_x", a_cx, h < HA ? h % CWID : 0);
    chk("a_text_col", a_col, h < HA ? (h / CWID) % (1 << CWB) : 0);
    chk("a_cell_y", a_cy, v < VA ? v % CHGT : 0);
    chk("a_text_row", a_row, v < VA ? (v / CHGT) % (1 << RWB) : 0);
    chk("a_line_start", a_ls, stepped && h == 0);
    chk("a_frame_start", a_fs, stepped && p % FR == 0);
    chk("a_vblank_irq", a_vb, stepped && h == 0 && v == VA);
    chk("a_frame_count", a_fc, (p / FR) % 65536);
  endtask

  task automatic step_a(input logic r, input logic e);
    @(negedge clk);
    rst_a = r;
    en_a = e;
    #1 check_a();
    @(posedge clk);
    if (r) begin
      ph = 0; p = 0; stepped = 0;
    end else if (e) begin
      stepped = ph == PD - 1;
      if (stepped) p++;
      ph = (ph + 1) % PD;
    end else stepped = 0;
  endtask

  typedef struct {
    int n;
    logic en;
    logic [3:0] h;
    logic [2:0] v;
    logic hs, vs, ls, fs, vb;
    logic [15:0] fc;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{0,   1'b1, 4'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{9,   1'b0, 4'd9,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[2]  = '{10,  1'b1, 4'd10, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[3]  = '{11,  1'b1, 4'd11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[4]  = '{12,  1'b1, 4'd0,  3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[5]  = '{48,  1'b0, 4'd0,  3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vt[6]  = '{60,  1'b1, 4'd0,  3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[7]  = '{61,  1'b1, 4'd1,  3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[8]  = '{83,  1'b1, 4'd11, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[9]  = '{84,  1'b1, 4'd0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vt[10] = '{168, 1'b1, 4'd0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst_b = 1'b1;
      en_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      en_b = 1'b1;
      repeat (vt[i].n) @(negedge clk);
      en_b = vt[i].en;
      #1;
      chk("b_pix_stb", b_stb, vt[i].en);
      chk("b_hcount", b_h, vt[i].h);
      chk("b_vcount", b_v, vt[i].v);
      chk("b_hsync", b_hs, vt[i].hs);
      chk("b_vsync", b_vs, vt[i].vs);
      chk("b_line_start", b_ls, vt[i].ls);
      chk("b_frame_start", b_fs, vt[i].fs);
      chk("b_vblank_irq", b_vb, vt[i].vb);
      chk("b_frame_count", b_fc, vt[i].fc);
    end
    step_a(1'b1, 1'b1);
    repeat (PD * FR * 5 + PD * (HT * 7 + 10) + 1) step_a(1'b0, 1'b1);
    repeat (37) step_a(1'b0, 1'b0);
    repeat (2 * PD * HT) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    repeat (3) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b0);
    repeat (PD * FR + 5) step_a(1'b0, 1'b1);
    repeat (20000) step_a($urandom_range(0, 2999) == 0, $urandom_range(0, 9) < 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
